// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control slice.
// Optional feature macro: LAP_CNT_EN (adds the BCD lap counter to stopwatch_ctrl).
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_SPLIT = 2'd3
   } state_t;

   // Resolved button command after same-cycle priority (reset > stop > start > split)
   typedef enum logic [2:0] {
      CMD_NONE  = 3'd0,
      CMD_RESET = 3'd1,
      CMD_STOP  = 3'd2,
      CMD_START = 3'd3,
      CMD_SPLIT = 3'd4
   } cmd_t;

   typedef logic [7:0] bcd_t;

   typedef struct packed {
      bcd_t min;
      bcd_t sec;
      bcd_t cs;
   } time_t;

   localparam int CS_MAX  = 99;
   localparam int SEC_MAX = 59;

   // Binary 0..99 to two-digit BCD {tens, units}
   function automatic bcd_t to_bcd(input int v);
      logic [3:0] tens;
      logic [3:0] units;
      tens  = 4'(v / 10);
      units = 4'(v % 10);
      return {tens, units};
   endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_pair_cnt.sv
// Two-digit BCD counter that wraps to 00 after LIMIT; carry is high on the
// increment that wraps, so counters chain within one cycle.
module bcd_pair_cnt
   import stopwatch_pkg::*;
#(
   parameter int LIMIT = 99
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inc,
   input  logic       clr,
   output logic [7:0] value,
   output logic       carry
);

   localparam bcd_t LIM_BCD = to_bcd(LIMIT);

   logic at_limit;

   assign at_limit = (value == LIM_BCD);
   assign carry    = inc && at_limit;

   // Clear has priority; units roll 9->0 into the tens digit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= '0;
      end else if (clr) begin
         value <= '0;
      end else if (inc) begin
         if (at_limit) begin
            value <= '0;
         end else if (value[3:0] == 4'd9) begin
            value <= {value[7:4] + 4'd1, 4'd0};
         end else begin
            value <= {value[7:4], value[3:0] + 4'd1};
         end
      end
   end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: run/pause/split FSM, MM:SS.cc BCD live count, split hold
// register and registered display outputs.
// Optional feature macro: LAP_CNT_EN adds lap_num, a BCD count of split captures.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | cleared / stopped, waiting for start
// ST_RUN   | counting, display shows the live count
// ST_PAUSE | count held, display shows the live count
// ST_SPLIT | counting, display frozen on the captured split value
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int MIN_MAX = 59
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick_100hz,
   input  logic       start,
   input  logic       stop,
   input  logic       split,
   input  logic       reset,
   output logic [7:0] disp_min,
   output logic [7:0] disp_sec,
   output logic [7:0] disp_cs,
   output logic       running,
   output logic       split_act,
   output logic       wrapped
`ifdef LAP_CNT_EN
   ,
   output logic [7:0] lap_num
`endif
);

   state_t state;
   state_t state_nxt;
   cmd_t   cmd;
   logic   clr_cnt;
   logic   capture;
   logic   cnt_en;
   logic   cs_carry;
   logic   sec_carry;
   logic   min_carry;
   time_t  live;
   time_t  split_hold;

   // Resolve simultaneous pulses so only the highest-priority one acts
   always_comb begin
      cmd = CMD_NONE;
      if (reset)      cmd = CMD_RESET;
      else if (stop)  cmd = CMD_STOP;
      else if (start) cmd = CMD_START;
      else if (split) cmd = CMD_SPLIT;
   end

   // Next state plus the count-clear and split-capture strobes for this edge
   always_comb begin
      state_nxt = state;
      clr_cnt   = 1'b0;
      capture   = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (cmd == CMD_START)      state_nxt = ST_RUN;
            else if (cmd == CMD_RESET) clr_cnt   = 1'b1;
         end
         ST_RUN: begin
            if (cmd == CMD_STOP) begin
               state_nxt = ST_PAUSE;
            end else if (cmd == CMD_SPLIT) begin
               state_nxt = ST_SPLIT;
               capture   = 1'b1;
            end
         end
         ST_SPLIT: begin
            if (cmd == CMD_STOP)       state_nxt = ST_PAUSE;
            else if (cmd == CMD_SPLIT) state_nxt = ST_RUN;
         end
         ST_PAUSE: begin
            if (cmd == CMD_START) begin
               state_nxt = ST_RUN;
            end else if (cmd == CMD_RESET) begin
               state_nxt = ST_IDLE;
               clr_cnt   = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Counting is qualified by the pre-edge state, so a tick with start is lost
   // and a tick with stop is kept
   assign cnt_en = tick_100hz && ((state == ST_RUN) || (state == ST_SPLIT));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   bcd_pair_cnt #(.LIMIT(CS_MAX)) u_cs (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (cnt_en),
      .clr   (clr_cnt),
      .value (live.cs),
      .carry (cs_carry)
   );

   bcd_pair_cnt #(.LIMIT(SEC_MAX)) u_sec (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (cs_carry),
      .clr   (clr_cnt),
      .value (live.sec),
      .carry (sec_carry)
   );

   bcd_pair_cnt #(.LIMIT(MIN_MAX)) u_min (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (sec_carry),
      .clr   (clr_cnt),
      .value (live.min),
      .carry (min_carry)
   );

   // Split hold captures the pre-edge live count on RUN->SPLIT
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       split_hold <= '0;
      else if (clr_cnt) split_hold <= '0;
      else if (capture) split_hold <= live;
   end

   // Sticky wrap flag, set when minutes roll over from MIN_MAX
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         wrapped <= 1'b0;
      else if (clr_cnt)   wrapped <= 1'b0;
      else if (min_carry) wrapped <= 1'b1;
   end

   // Registered display and status, one clock behind count/state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         disp_min  <= '0;
         disp_sec  <= '0;
         disp_cs   <= '0;
         running   <= 1'b0;
         split_act <= 1'b0;
      end else begin
         if (state == ST_SPLIT) begin
            disp_min <= split_hold.min;
            disp_sec <= split_hold.sec;
            disp_cs  <= split_hold.cs;
         end else begin
            disp_min <= live.min;
            disp_sec <= live.sec;
            disp_cs  <= live.cs;
         end
         running   <= (state == ST_RUN) || (state == ST_SPLIT);
         split_act <= (state == ST_SPLIT);
      end
   end

`ifdef LAP_CNT_EN
   logic lap_carry;

   bcd_pair_cnt #(.LIMIT(99)) u_lap (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (capture),
      .clr   (clr_cnt),
      .value (lap_num),
      .carry (lap_carry)
   );
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: main instance at MIN_MAX=59, a second
// instance at MIN_MAX=1 so the minute wrap is reachable in a short run.
module tb_stopwatch_ctrl;

   logic clk;
   logic rst_n;
   logic tick_100hz, start, stop, split, reset;
   logic [7:0] disp_min, disp_sec, disp_cs;
   logic running, split_act, wrapped;
   logic tick2, start2, stop2, split2, reset2;
   logic [7:0] min2, sec2, cs2;
   logic running2, split_act2, wrapped2;
`ifdef LAP_CNT_EN
   logic [7:0] lap_num, lap_num2;
`endif

   int total = 0;
   int bad   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   stopwatch_ctrl #(.MIN_MAX(59)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick_100hz (tick_100hz),
      .start      (start),
      .stop       (stop),
      .split      (split),
      .reset      (reset),
      .disp_min   (disp_min),
      .disp_sec   (disp_sec),
      .disp_cs    (disp_cs),
      .running    (running),
      .split_act  (split_act),
      .wrapped    (wrapped)
`ifdef LAP_CNT_EN
      ,
      .lap_num    (lap_num)
`endif
   );

   stopwatch_ctrl #(.MIN_MAX(1)) dut_w (
      .clk        (clk),
      .rst_n      (rst_n),
      .tick_100hz (tick2),
      .start      (start2),
      .stop       (stop2),
      .split      (split2),
      .reset      (reset2),
      .disp_min   (min2),
      .disp_sec   (sec2),
      .disp_cs    (cs2),
      .running    (running2),
      .split_act  (split_act2),
      .wrapped    (wrapped2)
`ifdef LAP_CNT_EN
      ,
      .lap_num    (lap_num2)
`endif
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock with the given pulses on the main instance; returns at a negedge
   task automatic step(input logic t, input logic st, input logic sp,
                       input logic spl, input logic rs);
      tick_100hz = t; start = st; stop = sp; split = spl; reset = rs;
      @(posedge clk); #1;
      tick_100hz = 0; start = 0; stop = 0; split = 0; reset = 0;
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
   endtask

   task automatic check_time(input string tag, input logic [7:0] m,
                             input logic [7:0] s, input logic [7:0] c);
      check({tag, "_min"}, disp_min, m);
      check({tag, "_sec"}, disp_sec, s);
      check({tag, "_cs"},  disp_cs,  c);
   endtask

   initial begin
      rst_n = 0;
      tick_100hz = 0; start = 0; stop = 0; split = 0; reset = 0;
      tick2 = 0; start2 = 0; stop2 = 0; split2 = 0; reset2 = 0;
      repeat (3) @(negedge clk);

      check_time("rst", 8'h00, 8'h00, 8'h00);
      check("rst_running", {7'd0, running}, 8'h00);
      check("rst_split_act", {7'd0, split_act}, 8'h00);
      check("rst_wrapped", {7'd0, wrapped}, 8'h00);
      rst_n = 1;
      @(negedge clk);

      // IDLE ignores ticks
      ticks(5);
      idle(2);
      check_time("idle_ticks", 8'h00, 8'h00, 8'h00);

      // start, 150 ticks, stop, 20 more ticks
      step(0, 1, 0, 0, 0);
      ticks(150);
      idle(2);
      check_time("run150", 8'h00, 8'h01, 8'h50);
      check("run150_running", {7'd0, running}, 8'h01);
      step(0, 0, 1, 0, 0);
      ticks(20);
      idle(2);
      check_time("pause20", 8'h00, 8'h01, 8'h50);
      check("pause_running", {7'd0, running}, 8'h00);

      // reset+start together in PAUSE: reset wins -> IDLE, cleared
      step(0, 1, 0, 0, 1);
      ticks(4);
      idle(2);
      check_time("pause_reset", 8'h00, 8'h00, 8'h00);
      check("pause_reset_running", {7'd0, running}, 8'h00);

      // start+tick from IDLE: tick lost
      step(1, 1, 0, 0, 0);
      idle(2);
      check_time("start_tick", 8'h00, 8'h00, 8'h00);
      check("start_tick_running", {7'd0, running}, 8'h01);
      // stop+tick at 00.09: tick kept
      ticks(9);
      step(1, 0, 1, 0, 0);
      ticks(3);
      idle(2);
      check_time("stop_tick", 8'h00, 8'h00, 8'h10);
      check("stop_tick_running", {7'd0, running}, 8'h00);

      // reset in RUN has no effect
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 1);
      ticks(5);
      idle(2);
      check_time("run_reset", 8'h00, 8'h00, 8'h15);
      check("run_reset_running", {7'd0, running}, 8'h01);

      // reach 00:05.00 then split: display frozen while live keeps counting
      ticks(485);
      step(0, 0, 0, 1, 0);
      idle(2);
      check_time("split_cap", 8'h00, 8'h05, 8'h00);
      check("split_act_on", {7'd0, split_act}, 8'h01);
      ticks(300);
      idle(2);
      check_time("split_frozen", 8'h00, 8'h05, 8'h00);
      check("split_running", {7'd0, running}, 8'h01);
      step(0, 0, 0, 1, 0);
      idle(2);
      check_time("split_release", 8'h00, 8'h08, 8'h00);
      check("split_act_off", {7'd0, split_act}, 8'h00);

      // second split cycle, then stop from SPLIT shows the live count
      ticks(20);
      step(0, 0, 0, 1, 0);
      ticks(30);
      step(0, 0, 1, 0, 0);
      idle(2);
      check_time("split_stop", 8'h00, 8'h08, 8'h50);
      check("split_stop_act", {7'd0, split_act}, 8'h00);
      check("split_stop_running", {7'd0, running}, 8'h00);

`ifdef LAP_CNT_EN
      // two captures so far; a third from RUN
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      idle(2);
      check("lap_num", lap_num, 8'h03);
      step(0, 0, 1, 0, 0);
`endif

      // rst_n mid-RUN at 00:03.27
      step(0, 0, 0, 0, 1);
      step(0, 1, 0, 0, 0);
      ticks(327);
      idle(2);
      check_time("pre_rstn", 8'h00, 8'h03, 8'h27);
      rst_n = 0;
      #1;
      check_time("async_rstn", 8'h00, 8'h00, 8'h00);
      check("async_rstn_running", {7'd0, running}, 8'h00);
      @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      ticks(10);
      idle(2);
      check_time("post_rstn", 8'h00, 8'h00, 8'h00);
      check("post_rstn_running", {7'd0, running}, 8'h00);
`ifdef LAP_CNT_EN
      check("lap_rstn", lap_num, 8'h00);
`endif
      step(0, 1, 0, 0, 0);
      ticks(1);
      idle(2);
      check_time("restart", 8'h00, 8'h00, 8'h01);

      // wrap on the MIN_MAX=1 instance: 01:59.99 then 00:00.00
      start2 = 1;
      @(posedge clk); #1;
      start2 = 0;
      tick2 = 1;
      repeat (11999) @(posedge clk);
      #1;
      tick2 = 0;
      repeat (2) @(posedge clk);
      #1;
      check("wrap_pre_min", min2, 8'h01);
      check("wrap_pre_sec", sec2, 8'h59);
      check("wrap_pre_cs", cs2, 8'h99);
      check("wrap_pre_flag", {7'd0, wrapped2}, 8'h00);
      tick2 = 1;
      @(posedge clk); #1;
      tick2 = 0;
      repeat (2) @(posedge clk);
      #1;
      check("wrap_min", min2, 8'h00);
      check("wrap_sec", sec2, 8'h00);
      check("wrap_cs", cs2, 8'h00);
      check("wrap_flag", {7'd0, wrapped2}, 8'h01);
      // wrapped is sticky across further counting, cleared by reset from PAUSE
      tick2 = 1;
      repeat (7) @(posedge clk);
      #1;
      tick2 = 0;
      stop2 = 1;
      @(posedge clk); #1;
      stop2 = 0;
      repeat (2) @(posedge clk);
      #1;
      check("wrap_sticky", {7'd0, wrapped2}, 8'h01);
      check("wrap_after_cs", cs2, 8'h07);
      reset2 = 1;
      @(posedge clk); #1;
      reset2 = 0;
      repeat (2) @(posedge clk);
      #1;
      check("wrap_cleared", {7'd0, wrapped2}, 8'h00);
      check("wrap_cleared_cs", cs2, 8'h00);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
